// File: rtl/music_sequencer.sv
// music_sequencer
// Steps through a synchronous song ROM, holds each note for a programmed
// number of beats, and drives the square-wave tone generator.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   play       level, 1 = run, 0 = pause
//   restart    one-cycle pulse, rewind to address 0 and reload
//   vol_up     one-cycle pulse, volume level +1 (saturating)
//   vol_down   one-cycle pulse, volume level -1 (saturating)
//   mute       level, silences outputs while sequencing continues
//   song_addr  registered ROM address
//   song_data  ROM data, valid one cycle after song_addr
//   note_div   half-period count for the tone generator
//   volume_max / volume_min  +A / -A amplitude, two's complement
//   vol_level  current volume level 0..7
//   playing    1 while in PLAY
//
// ROM entry: [3:0] note (0 and 13..15 rest, 1..12 C4..B4), [4] octave up,
// [7:5] beats-1. 8'hFF marks the end of the song.
//
// state | meaning
// IDLE  | after reset, waiting for play
// FETCH | song_addr stable, ROM read in flight
// LOAD  | song_data valid, decode entry or handle end marker
// PLAY  | note sounding, beat/duration counters running
// PAUSE | counters frozen, outputs silent

module music_sequencer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BEAT_DIV = 12_500_000,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              restart,
    input  logic              vol_up,
    input  logic              vol_down,
    input  logic              mute,
    output logic [ADDR_W-1:0] song_addr,
    input  logic [7:0]        song_data,
    output logic [21:0]       note_div,
    output logic [15:0]       volume_max,
    output logic [15:0]       volume_min,
    output logic [2:0]        vol_level,
    output logic              playing
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSE} state_t;

    localparam int BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);

    // Equal-tempered half period in clocks, minus one, for note n (A4 = 10).
    function automatic logic [21:0] note_period(input int n);
        real f;
        real half;
        if (n < 1 || n > 12) begin
            return 22'd0;
        end
        f    = 440.0 * (2.0 ** ((real'(n) - 10.0) / 12.0));
        half = real'(CLK_FREQ) / (2.0 * f);
        return 22'($rtoi(half + 0.5) - 1);
    endfunction

    localparam logic [21:0] NOTE_TAB [16] = '{
        22'd0,           note_period(1),  note_period(2),  note_period(3),
        note_period(4),  note_period(5),  note_period(6),  note_period(7),
        note_period(8),  note_period(9),  note_period(10), note_period(11),
        note_period(12), 22'd0,           22'd0,           22'd0
    };

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
    logic [2:0]          dur_cnt, dur_cnt_nxt;
    logic [2:0]          dur, dur_nxt;
    logic                rest, rest_nxt;
    logic [21:0]         div_nxt;
    logic [2:0]          vol_nxt;
    logic [15:0]         amp;
    logic                sound;
    logic [21:0]         tab_val;

    assign tab_val = NOTE_TAB[song_data[3:0]];

    always_comb begin
        state_nxt   = state;
        addr_nxt    = song_addr;
        beat_nxt    = beat_cnt;
        dur_cnt_nxt = dur_cnt;
        dur_nxt     = dur;
        rest_nxt    = rest;
        div_nxt     = note_div;

        case (state)
            IDLE: begin
                if (play) state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                if (song_data == 8'hFF) begin
                    addr_nxt  = '0;
                    state_nxt = FETCH;
                end else begin
                    rest_nxt    = (song_data[3:0] == 4'd0) || (song_data[3:0] > 4'd12);
                    div_nxt     = song_data[4] ? (tab_val >> 1) : tab_val;
                    dur_nxt     = song_data[7:5];
                    beat_nxt    = '0;
                    dur_cnt_nxt = '0;
                    addr_nxt    = song_addr + 1'b1;
                    state_nxt   = play ? PLAY : PAUSE;
                end
            end
            PLAY: begin
                // The counters advance on the cycle play drops, so the
                // total time spent in PLAY per note is exact across pauses.
                if (beat_cnt == BEAT_LAST) begin
                    beat_nxt = '0;
                    if (dur_cnt == dur) state_nxt = FETCH;
                    else                dur_cnt_nxt = dur_cnt + 1'b1;
                end else begin
                    beat_nxt = beat_cnt + 1'b1;
                end
                if (state_nxt != FETCH && !play) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (play) state_nxt = PLAY;
            end
            default: state_nxt = IDLE;
        endcase

        if (restart) begin
            state_nxt   = FETCH;
            addr_nxt    = '0;
            beat_nxt    = '0;
            dur_cnt_nxt = '0;
        end
    end

    always_comb begin
        vol_nxt = vol_level;
        if (vol_up && !vol_down && vol_level != 3'd7)      vol_nxt = vol_level + 1'b1;
        else if (vol_down && !vol_up && vol_level != 3'd0) vol_nxt = vol_level - 1'b1;
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe.
    assign amp   = {2'b00, vol_nxt, 11'd0};
    assign sound = (state_nxt == PLAY) && !rest_nxt && !mute;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            song_addr  <= '0;
            beat_cnt   <= '0;
            dur_cnt    <= '0;
            dur        <= '0;
            rest       <= 1'b0;
            note_div   <= '0;
            volume_max <= '0;
            volume_min <= '0;
            vol_level  <= 3'd4;
            playing    <= 1'b0;
        end else begin
            state      <= state_nxt;
            song_addr  <= addr_nxt;
            beat_cnt   <= beat_nxt;
            dur_cnt    <= dur_cnt_nxt;
            dur        <= dur_nxt;
            rest       <= rest_nxt;
            note_div   <= div_nxt;
            volume_max <= sound ? amp : 16'd0;
            volume_min <= sound ? (16'd0 - amp) : 16'd0;
            vol_level  <= vol_nxt;
            playing    <= (state_nxt == PLAY);
        end
    end

endmodule
